// File: rtl/work_scheduler_pkg.sv
// Shared types for the work scheduler: FSM state encoding and default sizing.
package work_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_WORK    = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_IDW   = 2;

endpackage

// File: rtl/work_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr_i, wrapping.
// The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            grant_valid_o
);

  logic [IDW-1:0] k_idx;
  logic           found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    k_idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k_idx = IDW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[k_idx]) begin
        found          = 1'b1;
        grant_o[k_idx] = 1'b1;
        grant_idx_o    = k_idx;
      end
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/work_scheduler.sv
// Shares one add + work-step datapath between NREQ requesters with round-robin
// arbitration; one operation in flight, result returned tagged with requester ID.
module work_scheduler
  import work_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = DEF_IDW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH:0]        rsp_sum_o,
  output logic [WIDTH:0]        rsp_result_o,
  output logic                  busy_o,
  output state_e                dbg_state_o
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high.
  // req_ready_o is combinational from valid and may only rise in IDLE; rsp_valid_o
  // holds with stable payload until rsp_ready_i, and no request is taken that cycle.

  localparam logic [WIDTH:0] WORK_MASK = (WIDTH+1)'(1) << (WIDTH-1);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0] sum_q, sum_d, result_q, result_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   work_x;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i         (req_valid_i),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        a_sel = req_a_i[k*WIDTH +: WIDTH];
        b_sel = req_b_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    result_d    = result_q;
    req_ready_o = '0;
    work_x      = ~sum_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          req_ready_o = grant;
          a_d         = a_sel;
          b_d         = b_sel;
          id_d        = grant_idx;
          ptr_d       = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
          state_d     = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        state_d = ST_WORK;
      end
      ST_WORK: begin
        result_d = (work_x | WORK_MASK) & ~sum_q;
        state_d  = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  assign rsp_valid_o  = (state_q == ST_RESPOND);
  assign rsp_id_o     = id_q;
  assign rsp_sum_o    = sum_q;
  assign rsp_result_o = result_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_work_scheduler.sv
// Directed bench for work_scheduler: vector table for single ops plus hand-written
// sequences for fairness, backpressure, pointer wrap and reset mid-operation.
module tb_work_scheduler;
  import work_scheduler_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_a_i;
  logic [NREQ*WIDTH-1:0] req_b_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH:0]        rsp_sum_o;
  logic [WIDTH:0]        rsp_result_o;
  logic                  busy_o;
  state_e                dbg_state_o;

  work_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_sum_o    (rsp_sum_o),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [IDW+WIDTH:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid_i[k]               = 1'b1;
    req_a_i[k*WIDTH +: WIDTH]    = a;
    req_b_i[k*WIDTH +: WIDTH]    = b;
  endtask

  task automatic apply_reset();
    rst_i       = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_i);
      if (req_ready_o[k]) ok = 1'b1;
    end
    if (!ok) check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk_i);
      lat++;
      if (rsp_valid_o) break;
    end
    if (!rsp_valid_o) check("wait_rsp_timeout", 32'd0, 32'd1);
  endtask

  // Full operation with rsp_ready_i=1; returns at #1 after the handshake edge.
  task automatic run_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    int lat;
    set_req(k, a, b);
    wait_ready(k, ok);
    @(posedge clk_i);
    #1 req_valid_i[k] = 1'b0;
    wait_rsp(lat);
    check("run_op_id", 32'(rsp_id_o), 32'(k));
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0] exp_sum;
    logic [WIDTH:0] exp_result;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int lat;
    int last_cyc;
    int highs;
    logic [IDW+WIDTH:0] e;
    logic [WIDTH-1:0] fa, fb;

    vecs[0] = '{2, 8'h03, 8'h05, 9'h008, 9'h1F7};
    vecs[1] = '{0, 8'h80, 8'h00, 9'h080, 9'h17F};
    vecs[2] = '{3, 8'hFF, 8'hFF, 9'h1FE, 9'h001};
    vecs[3] = '{1, 8'h12, 8'h34, 9'h046, 9'h1B9};
    vecs[4] = '{1, 8'h0A, 8'hF6, 9'h100, 9'h0FF};
    vecs[5] = '{0, 8'h00, 8'h00, 9'h000, 9'h1FF};

    req_a_i = '0;
    req_b_i = '0;
    apply_reset();

    // Reset state
    @(negedge clk_i);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_id", 32'(rsp_id_o), 32'd0);
    check("rst_sum", 32'(rsp_sum_o), 32'd0);
    check("rst_result", 32'(rsp_result_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));

    // Single operations from the table
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      wait_ready(vecs[v].id, ok);
      check("vec_req_ready", 32'(req_ready_o), 32'd1 << vecs[v].id);
      check("vec_idle_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i);
      #1 req_valid_i = '0;
      wait_rsp(lat);
      check("vec_latency", 32'(lat), 32'd3);
      check("vec_id", 32'(rsp_id_o), 32'(vecs[v].id));
      check("vec_sum", 32'(rsp_sum_o), 32'(vecs[v].exp_sum));
      check("vec_result", 32'(rsp_result_o), 32'(vecs[v].exp_result));
      check("vec_busy", 32'(busy_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      check("vec_rsp_drop", 32'(rsp_valid_o), 32'd0);
      check("vec_back_idle", 32'(dbg_state_o), 32'(ST_IDLE));
    end

    // Fairness: all requesters valid continuously
    apply_reset();
    for (int k = 0; k < NREQ; k++) begin
      fa = WIDTH'(8'h10 * k + 1);
      fb = WIDTH'(k);
      set_req(k, fa, fb);
    end
    for (int n = 0; n < 5; n++) begin
      fa = req_a_i[(n % NREQ)*WIDTH +: WIDTH];
      fb = req_b_i[(n % NREQ)*WIDTH +: WIDTH];
      exp_q.push_back({IDW'(n % NREQ), {1'b0, fa} + {1'b0, fb}});
    end
    last_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(lat);
      e = exp_q.pop_front();
      check("fair_id", 32'(rsp_id_o), 32'(e[IDW+WIDTH -: IDW]));
      check("fair_sum", 32'(rsp_sum_o), 32'(e[WIDTH:0]));
      if (n > 0) check("fair_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc = cyc;
      @(posedge clk_i);
      #1;
      if (n == 4) req_valid_i = '0;
    end

    // Backpressure: hold response for 10 cycles with other requesters pending
    rsp_ready_i = 1'b0;
    set_req(1, 8'h55, 8'hAA);
    wait_ready(1, ok);
    @(posedge clk_i);
    #1 req_valid_i = '1;
    wait_rsp(lat);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      check("bp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_id", 32'(rsp_id_o), 32'd1);
      check("bp_sum", 32'(rsp_sum_o), 32'h0FF);
      check("bp_result", 32'(rsp_result_o), 32'h100);
      check("bp_req_ready", 32'(req_ready_o), 32'd0);
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_released", 32'(rsp_valid_o), 32'd0);
    check("bp_busy", 32'(busy_o), 32'd0);
    highs = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (rsp_valid_o) highs++;
    end
    check("bp_single_rsp", 32'(highs), 32'd0);

    // Wrap: pointer at 3, only requester 1 valid
    apply_reset();
    run_op(2, 8'h01, 8'h01);
    @(negedge clk_i);
    set_req(1, 8'h02, 8'h02);
    #1 check("wrap_grant1", 32'(req_ready_o), 32'b0010);
    run_op(1, 8'h02, 8'h02);
    @(negedge clk_i);
    set_req(1, 8'h03, 8'h03);
    set_req(2, 8'h04, 8'h04);
    #1 check("wrap_ptr2", 32'(req_ready_o), 32'b0100);
    req_valid_i = '0;
    @(negedge clk_i);
    set_req(1, 8'h03, 8'h03);
    #1 check("wrap_regrant1", 32'(req_ready_o), 32'b0010);
    run_op(1, 8'h03, 8'h03);

    // Reset in the middle of WORK
    set_req(0, 8'h11, 8'h22);
    wait_ready(0, ok);
    @(posedge clk_i);
    #1 req_valid_i = '0;
    @(posedge clk_i);
    #1 check("mid_state_work", 32'(dbg_state_o), 32'(ST_WORK));
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    highs = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (rsp_valid_o) highs++;
    end
    check("mid_no_rsp", 32'(highs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
